// File: rtl/seg_display_arbiter_if.sv
// Bundle of request/data inputs and display outputs shared between the
// requesters (master side) and the display arbiter (slave side).
interface seg_display_arbiter_if;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic        hold;
    logic        sel_en;
    logic [1:0]  sel;
    logic [3:0]  ack;
    logic [7:0]  disp_num;
    logic [1:0]  disp_src;
    logic        disp_valid;

    modport master (
        output req, data_in, hold, sel_en, sel,
        input  ack, disp_num, disp_src, disp_valid
    );

    modport slave (
        input  req, data_in, hold, sel_en, sel,
        output ack, disp_num, disp_src, disp_valid
    );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing one seven-segment display between four
// requesters, with a fixed dwell per grant, a freeze input and a manual
// source override.
module seg_display_arbiter #(
    parameter int DWELL_CYCLES = 50000000,
    parameter int TW           = $clog2(DWELL_CYCLES) + 1
) (
    input logic                 clk,
    input logic                 rst_n,
    seg_display_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHOW   = 2'd1;
    localparam logic [1:0] MANUAL = 2'd2;

    localparam logic [TW-1:0] RELOAD = TW'(DWELL_CYCLES - 1);

    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic [1:0]    last;
    logic [1:0]    win;
    logic [1:0]    cand;
    logic          found;
    logic          do_grant;
    logic [7:0]    win_data;
    logic [7:0]    cur_data;
    logic [7:0]    sel_data;

    assign win_data = bus.data_in[{win, 3'b000} +: 8];
    assign cur_data = bus.data_in[{bus.disp_src, 3'b000} +: 8];
    assign sel_data = bus.data_in[{bus.sel, 3'b000} +: 8];

    // Round-robin search starting one past the last grant, wrapping to last.
    always_comb begin
        win   = last;
        found = 1'b0;
        cand  = last;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && bus.req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    // A grant fires from IDLE or at the end of a dwell, unless override/freeze.
    always_comb begin
        do_grant = !bus.sel_en && !bus.hold && found &&
                   ((state == IDLE) || (state == SHOW && timer == '0));
    end

    // Arbiter state, dwell timer and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            timer          <= '0;
            last           <= 2'd3;
            bus.ack        <= '0;
            bus.disp_num   <= '0;
            bus.disp_src   <= '0;
            bus.disp_valid <= 1'b0;
        end else begin
            bus.ack <= '0;
            if (bus.sel_en) begin
                state          <= MANUAL;
                bus.disp_src   <= bus.sel;
                bus.disp_num   <= sel_data;
                bus.disp_valid <= 1'b1;
                timer          <= RELOAD;
                last           <= bus.sel;
            end else if (bus.hold) begin
                // frozen: nothing changes, ack already cleared
            end else if (do_grant) begin
                state          <= SHOW;
                bus.disp_num   <= win_data;
                bus.disp_src   <= win;
                bus.disp_valid <= 1'b1;
                bus.ack        <= 4'b0001 << win;
                timer          <= RELOAD;
                last           <= win;
            end else begin
                case (state)
                    SHOW: begin
                        if (timer != '0) begin
                            timer <= timer - 1'b1;
                            if (bus.req[bus.disp_src]) begin
                                bus.disp_num <= cur_data;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end
                    MANUAL: begin
                        // leaving override starts a full dwell on the manual source
                        state <= SHOW;
                        timer <= RELOAD;
                        if (bus.req[bus.disp_src]) begin
                            bus.disp_num <= cur_data;
                        end
                    end
                    IDLE: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter with a short dwell; expected
// grants are queued when stimulus is applied and popped on each ack pulse.
module tb_seg_display_arbiter;

    localparam int DWELL = 4;

    typedef struct packed {
        logic [3:0] ack;
        logic [7:0] num;
        logic [1:0] src;
        logic [7:0] gap;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t sb[$];

    seg_display_arbiter_if bus();

    seg_display_arbiter #(.DWELL_CYCLES(DWELL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_data(input int src, input logic [7:0] v);
        bus.data_in[src*8 +: 8] = v;
    endtask

    task automatic wait_ack(input int bound, output int cycles, output logic [3:0] a);
        cycles = -1;
        a      = '0;
        for (int i = 1; i <= bound; i++) begin
            step(1);
            if (bus.ack !== 4'b0000) begin
                cycles = i;
                a      = bus.ack;
                return;
            end
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        bus.req    = '0;
        bus.data_in = '0;
        bus.hold   = 1'b0;
        bus.sel_en = 1'b0;
        bus.sel    = '0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        int         cyc;
        logic [3:0] a;
        exp_t       e;
        do_reset();
        checks++;
        if ({bus.ack, bus.disp_num, bus.disp_src, bus.disp_valid} !== 15'b0) begin
            failures++;
            $display("FAIL reset_state: ack=%b num=%h src=%0d valid=%b, expected all zero",
                     bus.ack, bus.disp_num, bus.disp_src, bus.disp_valid);
        end
        set_data(0, 8'h55);
        bus.req = 4'b0001;
        sb.push_back('{ack: 4'b0001, num: 8'h55, src: 2'd0, gap: 8'd1});
        wait_ack(4, cyc, a);
        e = sb.pop_front();
        checks++;
        if ({a, bus.disp_num, bus.disp_src} !== {e.ack, e.num, e.src} || cyc != int'(e.gap)) begin
            failures++;
            $display("FAIL reset_pregrant: ack=%b num=%h src=%0d gap=%0d, expected ack=%b num=%h src=%0d gap=%0d",
                     a, bus.disp_num, bus.disp_src, cyc, e.ack, e.num, e.src, e.gap);
        end
        step(1);
        rst_n = 1'b0;
        #2;
        checks++;
        if ({bus.ack, bus.disp_num, bus.disp_src, bus.disp_valid} !== 15'b0) begin
            failures++;
            $display("FAIL reset_async: ack=%b num=%h src=%0d valid=%b, expected all zero without clock",
                     bus.ack, bus.disp_num, bus.disp_src, bus.disp_valid);
        end
        bus.req = '0;
        step(1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            checks++;
            if ({bus.ack, bus.disp_num, bus.disp_valid} !== 13'b0) begin
                failures++;
                $display("FAIL reset_idle%0d: ack=%b num=%h valid=%b, expected zeros", i,
                         bus.ack, bus.disp_num, bus.disp_valid);
            end
        end
    endtask

    task automatic test_single();
        int         cyc;
        logic [3:0] a;
        exp_t       e;
        do_reset();
        set_data(2, 8'hF6);
        bus.req = 4'b0100;
        sb.push_back('{ack: 4'b0100, num: 8'hF6, src: 2'd2, gap: 8'd1});
        sb.push_back('{ack: 4'b0100, num: 8'hF6, src: 2'd2, gap: 8'd4});
        for (int g = 0; g < 2; g++) begin
            wait_ack(8, cyc, a);
            e = sb.pop_front();
            checks++;
            if ({a, bus.disp_num, bus.disp_src, bus.disp_valid} !== {e.ack, e.num, e.src, 1'b1} ||
                cyc != int'(e.gap)) begin
                failures++;
                $display("FAIL single_grant%0d: ack=%b num=%h src=%0d valid=%b gap=%0d, expected ack=%b num=%h src=%0d valid=1 gap=%0d",
                         g, a, bus.disp_num, bus.disp_src, bus.disp_valid, cyc, e.ack, e.num, e.src, e.gap);
            end
            if (g == 0) begin
                step(1);
                checks++;
                if (bus.ack !== 4'b0000) begin
                    failures++;
                    $display("FAIL single_ack_pulse: ack=%b, expected 0000", bus.ack);
                end
                // account for the cycle consumed above in the next gap
                sb[0].gap = 8'd3;
            end
        end
    endtask

    task automatic test_round_robin();
        int         cyc;
        logic [3:0] a;
        exp_t       e;
        do_reset();
        set_data(0, 8'h11);
        set_data(1, 8'h22);
        set_data(2, 8'h33);
        set_data(3, 8'h44);
        bus.req = 4'b1011;
        sb.push_back('{ack: 4'b0001, num: 8'h11, src: 2'd0, gap: 8'd1});
        sb.push_back('{ack: 4'b0010, num: 8'h22, src: 2'd1, gap: 8'd4});
        sb.push_back('{ack: 4'b1000, num: 8'h44, src: 2'd3, gap: 8'd4});
        sb.push_back('{ack: 4'b0001, num: 8'h11, src: 2'd0, gap: 8'd4});
        sb.push_back('{ack: 4'b0010, num: 8'h22, src: 2'd1, gap: 8'd4});
        for (int g = 0; g < 5; g++) begin
            wait_ack(8, cyc, a);
            e = sb.pop_front();
            checks++;
            if ({a, bus.disp_num, bus.disp_src} !== {e.ack, e.num, e.src} || cyc != int'(e.gap)) begin
                failures++;
                $display("FAIL rr_grant%0d: ack=%b num=%h src=%0d gap=%0d, expected ack=%b num=%h src=%0d gap=%0d",
                         g, a, bus.disp_num, bus.disp_src, cyc, e.ack, e.num, e.src, e.gap);
            end
        end
    endtask

    task automatic test_live_track();
        int         cyc;
        logic [3:0] a;
        exp_t       e;
        do_reset();
        set_data(1, 8'd10);
        bus.req = 4'b0010;
        sb.push_back('{ack: 4'b0010, num: 8'd10, src: 2'd1, gap: 8'd1});
        wait_ack(4, cyc, a);
        e = sb.pop_front();
        checks++;
        if ({a, bus.disp_num, bus.disp_src} !== {e.ack, e.num, e.src} || cyc != int'(e.gap)) begin
            failures++;
            $display("FAIL live_grant: ack=%b num=%h src=%0d gap=%0d, expected ack=%b num=%h src=%0d gap=%0d",
                     a, bus.disp_num, bus.disp_src, cyc, e.ack, e.num, e.src, e.gap);
        end
        for (int v = 11; v <= 12; v++) begin
            set_data(1, 8'(v));
            step(1);
            checks++;
            if (bus.disp_num !== 8'(v) || bus.ack !== 4'b0000) begin
                failures++;
                $display("FAIL live_track%0d: num=%0d ack=%b, expected num=%0d ack=0000",
                         v, bus.disp_num, bus.ack, v);
            end
        end
        bus.req = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) set_data(1, 8'd99);
            step(1);
            checks++;
            if ({bus.ack, bus.disp_num, bus.disp_src, bus.disp_valid} !== {4'b0000, 8'd12, 2'd1, 1'b1}) begin
                failures++;
                $display("FAIL live_idle%0d: ack=%b num=%0d src=%0d valid=%b, expected ack=0000 num=12 src=1 valid=1",
                         i, bus.ack, bus.disp_num, bus.disp_src, bus.disp_valid);
            end
        end
        set_data(0, 8'h05);
        bus.req = 4'b0011;
        sb.push_back('{ack: 4'b0001, num: 8'h05, src: 2'd0, gap: 8'd1});
        wait_ack(4, cyc, a);
        e = sb.pop_front();
        checks++;
        if ({a, bus.disp_num, bus.disp_src} !== {e.ack, e.num, e.src} || cyc != int'(e.gap)) begin
            failures++;
            $display("FAIL live_resume: ack=%b num=%h src=%0d gap=%0d, expected ack=%b num=%h src=%0d gap=%0d",
                     a, bus.disp_num, bus.disp_src, cyc, e.ack, e.num, e.src, e.gap);
        end
    endtask

    task automatic test_hold();
        int         cyc;
        logic [3:0] a;
        exp_t       e;
        do_reset();
        set_data(0, 8'hA0);
        bus.req = 4'b0001;
        sb.push_back('{ack: 4'b0001, num: 8'hA0, src: 2'd0, gap: 8'd1});
        wait_ack(4, cyc, a);
        e = sb.pop_front();
        checks++;
        if ({a, bus.disp_num, bus.disp_src} !== {e.ack, e.num, e.src} || cyc != int'(e.gap)) begin
            failures++;
            $display("FAIL hold_pregrant: ack=%b num=%h src=%0d gap=%0d, expected ack=%b num=%h src=%0d gap=%0d",
                     a, bus.disp_num, bus.disp_src, cyc, e.ack, e.num, e.src, e.gap);
        end
        step(1);
        bus.hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_data(0, 8'hA1 + 8'(i));
            step(1);
            checks++;
            if (bus.ack !== 4'b0000 || bus.disp_num !== 8'hA0) begin
                failures++;
                $display("FAIL hold_frozen%0d: ack=%b num=%h, expected ack=0000 num=a0",
                         i, bus.ack, bus.disp_num);
            end
        end
        bus.hold = 1'b0;
        sb.push_back('{ack: 4'b0001, num: 8'hAA, src: 2'd0, gap: 8'd3});
        wait_ack(8, cyc, a);
        e = sb.pop_front();
        checks++;
        if ({a, bus.disp_num, bus.disp_src} !== {e.ack, e.num, e.src} || cyc != int'(e.gap)) begin
            failures++;
            $display("FAIL hold_release: ack=%b num=%h src=%0d gap=%0d, expected ack=%b num=%h src=%0d gap=%0d",
                     a, bus.disp_num, bus.disp_src, cyc, e.ack, e.num, e.src, e.gap);
        end
    endtask

    task automatic test_manual();
        int         cyc;
        logic [3:0] a;
        exp_t       e;
        do_reset();
        set_data(0, 8'h50);
        set_data(3, 8'h70);
        bus.req = 4'b0001;
        sb.push_back('{ack: 4'b0001, num: 8'h50, src: 2'd0, gap: 8'd1});
        wait_ack(4, cyc, a);
        e = sb.pop_front();
        checks++;
        if ({a, bus.disp_num, bus.disp_src} !== {e.ack, e.num, e.src} || cyc != int'(e.gap)) begin
            failures++;
            $display("FAIL manual_pregrant: ack=%b num=%h src=%0d gap=%0d, expected ack=%b num=%h src=%0d gap=%0d",
                     a, bus.disp_num, bus.disp_src, cyc, e.ack, e.num, e.src, e.gap);
        end
        bus.sel_en = 1'b1;
        bus.sel    = 2'd3;
        bus.hold   = 1'b1;
        step(1);
        checks++;
        if ({bus.ack, bus.disp_num, bus.disp_src, bus.disp_valid} !== {4'b0000, 8'h70, 2'd3, 1'b1}) begin
            failures++;
            $display("FAIL manual_enter: ack=%b num=%h src=%0d valid=%b, expected ack=0000 num=70 src=3 valid=1",
                     bus.ack, bus.disp_num, bus.disp_src, bus.disp_valid);
        end
        bus.hold = 1'b0;
        set_data(3, 8'h71);
        step(1);
        checks++;
        if ({bus.ack, bus.disp_num, bus.disp_src} !== {4'b0000, 8'h71, 2'd3}) begin
            failures++;
            $display("FAIL manual_track: ack=%b num=%h src=%0d, expected ack=0000 num=71 src=3",
                     bus.ack, bus.disp_num, bus.disp_src);
        end
        bus.req    = 4'b1001;
        bus.sel_en = 1'b0;
        sb.push_back('{ack: 4'b0001, num: 8'h50, src: 2'd0, gap: 8'd5});
        sb.push_back('{ack: 4'b1000, num: 8'h71, src: 2'd3, gap: 8'd4});
        for (int g = 0; g < 2; g++) begin
            wait_ack(10, cyc, a);
            e = sb.pop_front();
            checks++;
            if ({a, bus.disp_num, bus.disp_src} !== {e.ack, e.num, e.src} || cyc != int'(e.gap)) begin
                failures++;
                $display("FAIL manual_resume%0d: ack=%b num=%h src=%0d gap=%0d, expected ack=%b num=%h src=%0d gap=%0d",
                         g, a, bus.disp_num, bus.disp_src, cyc, e.ack, e.num, e.src, e.gap);
            end
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        bus.req     = '0;
        bus.data_in = '0;
        bus.hold    = 1'b0;
        bus.sel_en  = 1'b0;
        bus.sel     = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_live_track();
        test_hold();
        test_manual();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
Shares the single 4-digit seven-segment display between four requesters, for example the PC, ALU result, register readback and a debug value. Each requester offers a signed 8-bit value. The block grants one requester at a time, round-robin, and holds each grant for a fixed dwell time. Its disp_num output drives the num input of the seven-segment display driver, which renders the value as sign plus hundreds, tens and ones. The block also supports a freeze input and a manual source override.

Parameters:
DWELL_CYCLES, 50000000, number of clk cycles each grant stays on the display (minimum 1).
TW, $clog2(DWELL_CYCLES)+1, width of the dwell timer (derived; do not override).

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
req  input  4  per-source display request; level-sensitive.
data_in  input  32  source values, source i occupies bits [8i+7:8i]; two's-complement.
hold  input  1  freeze: while high, no grant, no timer change, no data update.
sel_en  input  1  manual override enable.
sel  input  2  manual source index; used only while sel_en=1.
ack  output  4  one-cycle pulse on bit i when source i is newly granted.
disp_num  output  8  value sent to the display driver.
disp_src  output  2  index of the source currently shown.
disp_valid  output  1  high once any value has been latched; stays high until reset.

Behaviour:
- Reset (rst_n=0, takes effect immediately, asynchronous):
  - state=IDLE; ack=0, disp_num=0, disp_src=0, disp_valid=0; timer=0.
  - Last-grant pointer=3, so the first search starts at source 0.
- Precedence each edge: sel_en > hold > normal arbitration.
- Round-robin search: check sources last+1, last+2, last+3, last (mod 4); the first with req=1 wins.
- Grant action, performed on one edge:
  - disp_num <= winning source's data; disp_src <= winner; disp_valid <= 1.
  - ack[winner] <= 1 for exactly the next cycle; all other ack bits 0.
  - timer <= DWELL_CYCLES-1; last <= winner; state <= SHOW.
- IDLE:
  - req==0: no change; display keeps the last value.
  - Any req bit high: grant action.
- SHOW:
  - timer!=0: timer decrements by 1.
  - req[disp_src]=1: disp_num <= that source's current data (live tracking, no ack).
  - req[disp_src]=0: disp_num is held.
  - timer==0 and any req high: grant action. If the current source is the only requester it is re-granted and a new ack is issued.
  - timer==0 and req==0: state <= IDLE; disp_num, disp_src and disp_valid are unchanged.
  - Each grant therefore stays on the display for exactly DWELL_CYCLES cycles when requests are continuous.
- MANUAL (entered on any edge with sel_en=1, from any state):
  - disp_src <= sel; disp_num <= data_in[sel] every cycle, regardless of req; disp_valid <= 1; ack=0.
  - timer <= DWELL_CYCLES-1; last <= sel.
  - On the first edge with sel_en=0: state <= SHOW with timer=DWELL_CYCLES-1, followed by normal dwell. The next search starts at sel+1.
- hold=1 with sel_en=0:
  - state, timer, disp_num, disp_src and last are all frozen; ack=0.
  - Requests arriving during hold are not lost. Because req is level-sensitive, they are arbitrated after hold drops.
- Simultaneous events:
  - sel_en and hold together: MANUAL wins.
  - hold rising on the same edge the timer hits 0: hold wins; the grant happens on the first edge after hold falls.
- DWELL_CYCLES=1: the timer is always 0 in SHOW, so the block re-arbitrates every cycle.
- Sign handling: values pass through unmodified; sign and magnitude are handled by the display driver.
- Outputs are registered. ack is never high for more than one consecutive cycle for the same grant.

Test Plan:
1. Reset: assert rst_n=0 mid-SHOW with disp_num=8'h55 -> outputs go to 0 with no clock edge; after release with req=0, state stays IDLE and disp_valid=0.
2. Single requester (DWELL_CYCLES=4): req=4'b0100, source 2 data=8'hF6 (-10) -> one cycle later ack=4'b0100 for 1 cycle, disp_num=F6, disp_src=2, disp_valid=1. With req held, a second ack[2] arrives exactly 4 cycles after the first.
3. Round-robin: req=4'b1011 held, all sources with distinct data -> grant sequence 0,1,3,0,1 at 4-cycle spacing; source 2 is never acked.
4. Live track and idle: source 1 granted, source 1 data stepped 10,11,12 while req[1]=1 -> disp_num follows with 1-cycle lag. Drop req entirely -> IDLE after the dwell, and disp_num keeps 12.
5. Hold: assert hold for 10 cycles at timer=2 while source 0 data changes -> no ack, disp_num constant. After release the grant occurs 3 edges later.
6. Manual override: sel_en=1, sel=3 during SHOW of source 0 -> next cycle disp_src=3, disp_num tracks source 3 data, ack=0. Drop sel_en -> source 3 shown for 4 more cycles, then arbitration resumes from source 0.
